// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI path: h/v counters, fetch address stream,
// and sync/VDE delayed by LAT cycles to line up with pixel-source read data.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LAT      = 2
) (
  input  logic       pixclk,
  input  logic       reset_n,
  input  logic       en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       fetch_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       hSync_o,
  output logic       vSync_o,
  output logic       VDEn_o
);

  localparam int unsigned CW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]  h_cnt;
  logic [CW-1:0]  v_cnt;
  logic           active_c;
  logic           hs_c;
  logic           vs_c;
  logic           s0_hs;
  logic           s0_vs;
  logic           hs_lvl_c;
  logic           vs_lvl_c;
  logic [LAT-1:0] hs_dly;
  logic [LAT-1:0] vs_dly;
  logic [LAT-1:0] de_dly;

  // Raster decode of the current count
  always_comb begin
    active_c = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_c     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_c     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    hs_lvl_c = s0_hs ? HS_POL : ~HS_POL;
    vs_lvl_c = s0_vs ? VS_POL : ~VS_POL;
  end

  // Horizontal/vertical counters; hold while disabled
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Stage 0: decoded timing, blanked on disabled edges so each count is emitted once
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      pix_x       <= '0;
      pix_y       <= '0;
      fetch_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      s0_hs       <= 1'b0;
      s0_vs       <= 1'b0;
    end else if (en) begin
      pix_x       <= h_cnt[9:0];
      pix_y       <= v_cnt[9:0];
      fetch_valid <= active_c;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      s0_hs       <= hs_c;
      s0_vs       <= vs_c;
    end else begin
      fetch_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      s0_hs       <= 1'b0;
      s0_vs       <= 1'b0;
    end
  end

  // Delay line matching pixel-source latency; holds polarity-applied levels
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly <= {LAT{~HS_POL}};
      vs_dly <= {LAT{~VS_POL}};
      de_dly <= '0;
    end else begin
      hs_dly <= (hs_dly << 1) | LAT'(hs_lvl_c);
      vs_dly <= (vs_dly << 1) | LAT'(vs_lvl_c);
      de_dly <= (de_dly << 1) | LAT'(fetch_valid);
    end
  end

  assign hSync_o = hs_dly[LAT-1];
  assign vSync_o = vs_dly[LAT-1];
  assign VDEn_o  = de_dly[LAT-1];

endmodule
